// File: rtl/trig_sched.sv
// trig_sched: trigger scheduler for the RMII packet path (50 MHz network clock).
//
// Two trigger sources share one output:
//   - a periodic counter with a runtime-programmable period;
//   - a debounced rising-edge detector on a raw push-button.
// The scheduler emits a single-cycle pulse toward the packet transmitter.
// While the transmitter is busy, one trigger is held pending. Any further
// event that lands on an already-pending trigger is counted as a drop.
//
// Ports:
//   clk      in   network clock
//   rst      in   asynchronous reset, active-low
//   ready    in   PHY ready; low synchronously clears the scheduler state
//   mode     in   [0] periodic source enable, [1] button source enable
//   period   in   period in clk cycles (0 and 1 behave as 2)
//   btn      in   raw asynchronous push-button
//   busy     in   transmitter busy; no trigger is issued while high
//   trg      out  single-cycle trigger pulse
//   pending  out  a trigger is held, waiting for busy to fall
//   trg_cnt  out  issued triggers, wrapping
//   drop_cnt out  coalesced (lost) events, saturating at all-ones
module trig_sched #(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned DEB_W  = 24,
  parameter int unsigned STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ready,
  input  logic [1:0]        mode,
  input  logic [CNT_W-1:0]  period,
  input  logic              btn,
  input  logic              busy,
  output logic              trg,
  output logic              pending,
  output logic [STAT_W-1:0] trg_cnt,
  output logic [STAT_W-1:0] drop_cnt
);

  // Button synchroniser
  logic btn_s1_q;
  logic btn_s2_q;

  // Debounce tick counter and previous button sample
  logic [DEB_W-1:0] tick_q, tick_d;
  logic             prev_q, prev_d;

  // Periodic counter
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Arbitration and statistics
  logic              trg_q, trg_d;
  logic              pend_q, pend_d;
  logic [STAT_W-1:0] trg_cnt_q, trg_cnt_d;
  logic [STAT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Event strobes
  logic             tick;
  logic             btn_ev;
  logic             per_ev;
  logic             ev;
  logic             fire;
  logic [CNT_W-1:0] last_cnt;

  // The synchroniser keeps sampling while ready is low, so that the
  // previous-sample register can track the live button level and no
  // spurious edge is seen when ready rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_s1_q <= 1'b0;
      btn_s2_q <= 1'b0;
    end else begin
      btn_s1_q <= btn;
      btn_s2_q <= btn_s1_q;
    end
  end

  // Source events
  always_comb begin
    tick   = &tick_q;
    btn_ev = tick & btn_s2_q & ~prev_q & mode[1];

    // Terminal count is Peff-1 with Peff = max(period, 2).
    if (period < CNT_W'(2)) begin
      last_cnt = CNT_W'(1);
    end else begin
      last_cnt = period - CNT_W'(1);
    end

    // >= rather than == so that a period reduced below the current count
    // fires on the very next cycle instead of running to wrap-around.
    per_ev = mode[0] & (cnt_q >= last_cnt);

    ev   = per_ev | btn_ev;
    fire = (pend_q | ev) & ~busy;
  end

  // Next-state
  always_comb begin
    tick_d     = tick_q;
    prev_d     = prev_q;
    cnt_d      = cnt_q;
    trg_d      = 1'b0;
    pend_d     = pend_q;
    trg_cnt_d  = trg_cnt_q;
    drop_cnt_d = drop_cnt_q;

    if (!ready) begin
      tick_d     = '0;
      prev_d     = btn_s2_q;
      cnt_d      = '0;
      pend_d     = 1'b0;
      trg_cnt_d  = '0;
      drop_cnt_d = '0;
    end else begin
      tick_d = tick_q + DEB_W'(1);

      if (tick) begin
        prev_d = btn_s2_q;
      end

      if (!mode[0] || per_ev) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end

      trg_d  = fire;
      pend_d = busy & (pend_q | ev);

      if (fire) begin
        trg_cnt_d = trg_cnt_q + STAT_W'(1);
      end

      // An event that arrives while a trigger is already pending is lost,
      // whether busy is still high or the pending trigger is firing now.
      if (pend_q && ev && (drop_cnt_q != '1)) begin
        drop_cnt_d = drop_cnt_q + STAT_W'(1);
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_q     <= '0;
      prev_q     <= 1'b0;
      cnt_q      <= '0;
      trg_q      <= 1'b0;
      pend_q     <= 1'b0;
      trg_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      tick_q     <= tick_d;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      trg_q      <= trg_d;
      pend_q     <= pend_d;
      trg_cnt_q  <= trg_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign trg      = trg_q;
  assign pending  = pend_q;
  assign trg_cnt  = trg_cnt_q;
  assign drop_cnt = drop_cnt_q;

endmodule
